linebuf: RTL and testbench
==========================

LINEBUF -- requirements
Module: linebuf

Interface
REQ-001 Parameter MAXG, default 256: maximum 8-pixel groups per image line; line-store depth.
REQ-002 Parameter AW, default 8: column-counter width; 2**AW SHALL be >= MAXG.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ena  input  1  pipeline advance enable; no state changes when 0.
REQ-006 i_vl  input  1  input group valid.
REQ-007 i_sof  input  1  first group of a frame; qualified by i_vl.
REQ-008 i_w  input  AW  groups per line minus 1; sampled when i_sof is accepted.
REQ-009 i_x  input  8 x [7:0], indices 1..8  current-line pixels, left to right.
REQ-010 o_vl  output  1  output group valid.
REQ-011 o_sl  output  1  group lies on frame line 0.
REQ-012 o_sp  output  1  group is column 0 of its line.
REQ-013 o_b  output  9 x [7:0], indices 1..9  above-line pixels; index 9 is the pixel above-right of x[8].
REQ-014 o_x  output  8 x [7:0], indices 1..8  current pixels, delayed copy of i_x.

Function
REQ-015 A group SHALL be accepted iff ena=1 and i_vl=1 in a cycle, and state is not IDLE or i_sof=1.
REQ-016 States SHALL be: IDLE (no frame), LINE0 (first line), BODY (later lines).
REQ-017 IDLE -> LINE0 on acceptance with i_sof=1; any state -> LINE0 on acceptance with i_sof=1.
REQ-018 LINE0 -> BODY on acceptance of the group at column i_w; BODY stays BODY until i_sof or reset.
REQ-019 Groups with i_vl=1 in IDLE without i_sof SHALL be dropped: no output, no store write.
REQ-020 Column counter: cleared by accepted i_sof, then set to 1; otherwise incremented per accepted group; wraps to 0 after column i_w.
REQ-021 i_sof acceptance SHALL restart at column 0 of line 0, discarding any partial line.
REQ-022 Width register SHALL update only on accepted i_sof; i_w changes at other times are ignored.
REQ-023 Latency: an accepted group SHALL appear on outputs exactly 2 ena=1 cycles later with o_vl=1.
REQ-024 Bubbles (i_vl=0 or dropped groups) SHALL produce o_vl=0 in the matching output slot; column not advanced.
REQ-025 o_x[1..8] SHALL equal the accepted i_x[1..8] unchanged.
REQ-026 o_sp=1 iff group column = 0; o_sl=1 iff group is on line 0.
REQ-027 On line 0 o_b[1..9] SHALL be all 0.
REQ-028 Otherwise o_b[k] (k=1..8) SHALL equal pixel k of the same column on the previous line.
REQ-029 o_b[9] SHALL equal pixel 1 of column+1 on the previous line; at column i_w (including i_w=0) it SHALL equal o_b[8].
REQ-030 Line store SHALL hold MAXG x 64 bits; current group is written at its column after that column's previous-line data is read.
REQ-031 No read-before-write hazard: data for column+1 SHALL come from the previous line even when the writes to column and column+1 arrive back to back.
REQ-032 When ena=0, outputs, counters, state and store SHALL hold; o_vl is held, not cleared.
REQ-033 i_w >= MAXG is unsupported; behaviour unspecified.

Reset
REQ-034 On rst=1, immediately and asynchronously: o_vl=0, o_sl=0, o_sp=0, o_b=0, o_x=0, state=IDLE, column=0, width=0, pipeline valids=0.
REQ-035 Line-store contents are not reset; REQ-027 guarantees they are never exposed.
REQ-036 Reset mid-frame SHALL discard all in-flight groups; after release, operation resumes only on the next accepted i_sof.

Verification
REQ-037 i_w=1, ena=1, 2 lines, x groups 1..8, 9..16, 17..24, 25..32 -> output 1: sl=1, sp=1, b=0; output 2: sl=1, sp=0, b=0; output 3: sl=0, sp=1, b[1..8]=1..8, b[9]=9; output 4: b[1..8]=9..16, b[9]=16.
REQ-038 i_w=0, lines 1..8 then 9..16 -> second output b[1..8]=1..8, b[9]=8, sp=1, sl=0.
REQ-039 Same stimulus as REQ-037 with ena toggling 1,0 and i_vl bubbles -> identical output sequence over ena=1 cycles; outputs hold while ena=0; a bubble yields o_vl=0 in its slot.
REQ-040 i_w=3; i_sof reasserted at column 2 of line 1 -> that group has sp=1, sl=1, b=0; the next line's column 0 reads the restarted line's data.
REQ-041 rst pulsed mid-line 1 -> outputs 0 the same cycle; post-reset groups without i_sof give o_vl=0; the next i_sof group gives sl=1, sp=1 after 2 cycles.

Source files
------------

// File: rtl/linebuf_if.sv
// linebuf_if: pipeline enable, input pixel groups and output neighbourhood bundle
interface linebuf_if #(parameter int AW = 8);
   logic             ena;
   logic             i_vl;
   logic             i_sof;
   logic [AW-1:0]    i_w;
   logic [1:8][7:0]  i_x;
   logic             o_vl;
   logic             o_sl;
   logic             o_sp;
   logic [1:9][7:0]  o_b;
   logic [1:8][7:0]  o_x;
   modport master(output ena, i_vl, i_sof, i_w, i_x, input o_vl, o_sl, o_sp, o_b, o_x);
   modport slave(input ena, i_vl, i_sof, i_w, i_x, output o_vl, o_sl, o_sp, o_b, o_x);
endinterface

// File: rtl/linebuf.sv
// linebuf: one-line store pairing each 8-pixel group with the 9 pixels above it
module linebuf #(
   parameter int MAXG = 256,
   parameter int AW   = 8
) (
   input logic      clk,
   input logic      rst,
   linebuf_if.slave lb
);
   typedef enum logic [1:0] {IDLE, LINE0, BODY} state_t;
   state_t          state;
   logic [AW-1:0]   col, w, col_now, w_now, a1, s1_col;
   logic            acc, sof, last, sl_now;
   logic            s1_vl, s1_sl, s1_sp, s1_last;
   logic [1:8][7:0] s1_x, rd0, rd1;
   logic [1:8][7:0] mem [MAXG];
   // acceptance, effective column/width for this group, and the above-right read address
   always_comb begin
      acc = lb.ena && lb.i_vl && (state != IDLE || lb.i_sof);
      sof = acc && lb.i_sof;
      col_now = sof ? '0 : col;
      w_now = sof ? lb.i_w : w;
      last = col_now == w_now;
      a1 = last ? col_now : col_now + 1'b1;
      sl_now = sof || state == LINE0;
   end
   // frame control, stage-1 capture and registered outputs; everything freezes while ena=0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         col <= '0;
         w <= '0;
         s1_vl <= 1'b0;
         s1_sl <= 1'b0;
         s1_sp <= 1'b0;
         s1_last <= 1'b0;
         s1_col <= '0;
         s1_x <= '0;
         lb.o_vl <= 1'b0;
         lb.o_sl <= 1'b0;
         lb.o_sp <= 1'b0;
         lb.o_b <= '0;
         lb.o_x <= '0;
      end else if (lb.ena) begin
         s1_vl <= acc;
         if (acc) begin
            s1_sl <= sl_now;
            s1_sp <= col_now == '0;
            s1_last <= last;
            s1_col <= col_now;
            s1_x <= lb.i_x;
            col <= last ? '0 : col_now + 1'b1;
            state <= sl_now ? (last ? BODY : LINE0) : state;
         end
         if (sof) w <= lb.i_w;
         lb.o_vl <= s1_vl;
         lb.o_sl <= s1_sl;
         lb.o_sp <= s1_sp;
         lb.o_x <= s1_x;
         lb.o_b <= (s1_sl || !s1_vl) ? '0 : {rd0, s1_last ? rd0[8] : rd1[1]};
      end
   end
   // line store: write the previous group, read this group's column pair with bypass of that write
   always_ff @(posedge clk) begin
      if (lb.ena) begin
         if (s1_vl) mem[s1_col] <= s1_x;
         rd0 <= (s1_vl && s1_col == col_now) ? s1_x : mem[col_now];
         rd1 <= (s1_vl && s1_col == a1) ? s1_x : mem[a1];
      end
   end
endmodule

// File: tb/tb_linebuf.sv
// tb_linebuf: directed vectors for linebuf with hand-computed neighbourhoods
module tb_linebuf;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_run = 0;
   int   n_fail = 0;
   linebuf_if #(.AW(8)) lb();
   linebuf #(.MAXG(256), .AW(8)) dut (.clk(clk), .rst(rst), .lb(lb));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [63:0] grp(input int base);
      logic [63:0] r;
      for (int k = 0; k < 8; k++) r[63-8*k -: 8] = 8'(base + k);
      return r;
   endfunction
   task automatic drive(input bit e, input bit v, input bit s, input logic [7:0] w, input logic [63:0] x);
      lb.ena = e;
      lb.i_vl = v;
      lb.i_sof = s;
      lb.i_w = w;
      lb.i_x = x;
      @(posedge clk);
      #1;
   endtask
   task automatic expect_grp(input string tag, input bit sl, input bit sp, input logic [71:0] b, input logic [63:0] x);
      check({tag, "_vl"}, 72'(lb.o_vl), 72'(1));
      check({tag, "_sl"}, 72'(lb.o_sl), 72'(sl));
      check({tag, "_sp"}, 72'(lb.o_sp), 72'(sp));
      check({tag, "_b"}, 72'(lb.o_b), b);
      check({tag, "_x"}, 72'(lb.o_x), 72'(x));
   endtask
   initial begin
      drive(1, 0, 0, 0, 0);
      drive(1, 1, 1, 1, grp(1));
      check("rst_vl", 72'(lb.o_vl), 72'(0));
      check("rst_b", 72'(lb.o_b), 72'(0));
      check("rst_x", 72'(lb.o_x), 72'(0));
      rst = 1'b0;
      drive(1, 1, 0, 1, grp(1));
      drive(1, 0, 0, 1, 0);
      check("idle_drop", 72'(lb.o_vl), 72'(0));
      // two-column frame
      drive(1, 1, 1, 1, grp(1));
      drive(1, 1, 0, 1, grp(9));
      expect_grp("w1_o1", 1, 1, 72'(0), grp(1));
      drive(1, 1, 0, 1, grp(17));
      expect_grp("w1_o2", 1, 0, 72'(0), grp(9));
      drive(1, 1, 0, 1, grp(25));
      expect_grp("w1_o3", 0, 1, {grp(1), 8'd9}, grp(17));
      drive(1, 0, 0, 1, 0);
      expect_grp("w1_o4", 0, 0, {grp(9), 8'd16}, grp(25));
      drive(1, 0, 0, 1, 0);
      check("w1_tail", 72'(lb.o_vl), 72'(0));
      // single-column frame
      drive(1, 1, 1, 0, grp(1));
      drive(1, 1, 0, 0, grp(9));
      expect_grp("w0_o1", 1, 1, 72'(0), grp(1));
      drive(1, 0, 0, 0, 0);
      expect_grp("w0_o2", 0, 1, {grp(1), 8'd8}, grp(9));
      // enable gaps and bubbles
      drive(1, 1, 1, 1, grp(1));
      drive(0, 1, 1, 0, grp(99));
      drive(1, 1, 0, 1, grp(9));
      expect_grp("en_o1", 1, 1, 72'(0), grp(1));
      drive(0, 1, 0, 1, grp(77));
      expect_grp("en_hold1", 1, 1, 72'(0), grp(1));
      drive(1, 0, 0, 1, 0);
      expect_grp("en_o2", 1, 0, 72'(0), grp(9));
      drive(0, 0, 0, 1, 0);
      drive(1, 1, 0, 1, grp(17));
      check("en_bubble", 72'(lb.o_vl), 72'(0));
      drive(0, 1, 1, 1, grp(5));
      check("en_bubble_hold", 72'(lb.o_vl), 72'(0));
      drive(1, 1, 0, 1, grp(25));
      expect_grp("en_o3", 0, 1, {grp(1), 8'd9}, grp(17));
      drive(0, 0, 0, 1, 0);
      expect_grp("en_hold3", 0, 1, {grp(1), 8'd9}, grp(17));
      drive(1, 0, 0, 1, 0);
      expect_grp("en_o4", 0, 0, {grp(9), 8'd16}, grp(25));
      // restart mid-line with a four-column frame
      drive(1, 1, 1, 3, grp(1));
      drive(1, 1, 0, 3, grp(9));
      drive(1, 1, 0, 3, grp(17));
      drive(1, 1, 0, 3, grp(25));
      drive(1, 1, 0, 3, grp(33));
      expect_grp("rs_a3", 1, 0, 72'(0), grp(25));
      drive(1, 1, 0, 3, grp(41));
      drive(1, 1, 1, 3, grp(49));
      expect_grp("rs_b1", 0, 0, {grp(9), 8'd17}, grp(41));
      drive(1, 1, 0, 0, grp(57));
      expect_grp("rs_c0", 1, 1, 72'(0), grp(49));
      drive(1, 1, 0, 3, grp(65));
      drive(1, 1, 0, 3, grp(73));
      drive(1, 1, 0, 3, grp(81));
      drive(1, 0, 0, 3, 0);
      expect_grp("rs_d0", 0, 1, {grp(49), 8'd57}, grp(81));
      // asynchronous reset mid-line
      drive(1, 1, 1, 1, grp(1));
      drive(1, 1, 0, 1, grp(9));
      drive(1, 1, 0, 1, grp(17));
      #2 rst = 1'b1;
      #1;
      check("ar_vl", 72'(lb.o_vl), 72'(0));
      check("ar_x", 72'(lb.o_x), 72'(0));
      check("ar_sl", 72'(lb.o_sl), 72'(0));
      #1 rst = 1'b0;
      drive(1, 1, 0, 1, grp(25));
      check("ar_drop1", 72'(lb.o_vl), 72'(0));
      drive(1, 1, 0, 1, grp(33));
      check("ar_drop2", 72'(lb.o_vl), 72'(0));
      drive(1, 1, 1, 1, grp(41));
      check("ar_drop3", 72'(lb.o_vl), 72'(0));
      drive(1, 0, 0, 1, 0);
      expect_grp("ar_sof", 1, 1, 72'(0), grp(41));
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
